// File: rtl/cv32e40p_obi_resp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cv32e40p_obi_resp_pkg
// Description : Shared types and constants for the instruction-side OBI
//               responder and its response queue.
// Contents    : obi_resp_t  - one queued response {rdata, err}
//               ERR_RDATA   - read data returned with an error response
// Revision    : 1.0 - initial release
// ============================================================================
package cv32e40p_obi_resp_pkg;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } obi_resp_t;

    localparam logic [31:0] ERR_RDATA = 32'h0;

endpackage
`default_nettype wire

// File: rtl/cv32e40p_obi_resp_fifo.sv
`default_nettype none
// ============================================================================
// Module      : cv32e40p_obi_resp_fifo
// Description : DEPTH-entry in-order queue of OBI responses with synchronous
//               active-high reset. Push and pop in the same cycle are legal at
//               any occupancy, including full.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               i_push, i_data - write strobe and response to enqueue
//               i_pop          - remove head (ignored when empty)
//               o_head         - response at the head of the queue
//               o_empty/o_full - occupancy flags
// Revision    : 1.0 - initial release
// ============================================================================
module cv32e40p_obi_resp_fifo
    import cv32e40p_obi_resp_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      i_push,
    input  obi_resp_t i_data,
    input  logic      i_pop,
    output obi_resp_t o_head,
    output logic      o_empty,
    output logic      o_full
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = $clog2(DEPTH) + 1;
    localparam logic [c_PTR_W-1:0] c_LAST_IDX = c_PTR_W'(DEPTH - 1);
    localparam logic [c_CNT_W-1:0] c_DEPTH    = c_CNT_W'(DEPTH);

    obi_resp_t            r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_wptr;
    logic [c_PTR_W-1:0]   r_rptr;
    logic [c_CNT_W-1:0]   r_count;

    logic                 w_pop;
    logic [c_PTR_W-1:0]   w_wptr_nxt;
    logic [c_PTR_W-1:0]   w_rptr_nxt;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == c_DEPTH);
    assign o_head  = r_mem[r_rptr];

    // Popping an empty queue is a no-op rather than corrupting the pointers.
    assign w_pop = i_pop && !o_empty;

    // Explicit wrap keeps the pointers correct for any DEPTH, including 1.
    assign w_wptr_nxt = (r_wptr == c_LAST_IDX) ? '0 : r_wptr + 1'b1;
    assign w_rptr_nxt = (r_rptr == c_LAST_IDX) ? '0 : r_rptr + 1'b1;

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_wptr <= w_wptr_nxt;
            end
            if (w_pop) begin
                r_rptr <= w_rptr_nxt;
            end
            case ({i_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(i_push && o_full && !w_pop));
        end
    end
`endif

endmodule
`default_nettype wire

// File: rtl/cv32e40p_obi_instr_responder.sv
`default_nettype none
// ============================================================================
// Module      : cv32e40p_obi_instr_responder
// Description : OBI slave for the instruction fetch port. Grants word reads,
//               services them from a synchronous single-port memory and
//               returns responses strictly in order through a small queue.
//               Grant and response back-pressure can be injected via stalls.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               obi_req_i         - OBI request
//               obi_gnt_o         - OBI grant (combinational on request)
//               obi_addr_i        - OBI byte address, bits [1:0] ignored
//               obi_rvalid_o      - OBI response valid
//               obi_rdata_o       - OBI read data (0 when no response)
//               obi_err_o         - OBI error (0 when no response)
//               gnt_stall_i       - suppress grant
//               rvalid_stall_i    - hold back responses
//               mem_req_o         - memory read strobe
//               mem_addr_o        - memory word address
//               mem_rdata_i       - memory data, valid the cycle after strobe
// Revision    : 1.0 - initial release
// ============================================================================
module cv32e40p_obi_instr_responder
    import cv32e40p_obi_resp_pkg::*;
#(
    parameter int          DEPTH     = 2,
    parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
    parameter logic [31:0] ADDR_SIZE = 32'h0001_0000,
    parameter int          MEM_AW    = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              obi_req_i,
    output logic              obi_gnt_o,
    input  logic [31:0]       obi_addr_i,
    output logic              obi_rvalid_o,
    output logic [31:0]       obi_rdata_o,
    output logic              obi_err_o,
    input  logic              gnt_stall_i,
    input  logic              rvalid_stall_i,
    output logic              mem_req_o,
    output logic [MEM_AW-1:0] mem_addr_o,
    input  logic [31:0]       mem_rdata_i
);

    localparam int                 c_CNT_W = $clog2(DEPTH) + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(DEPTH);

    // Outstanding (granted, not yet responded) transaction count.
    logic [c_CNT_W-1:0] r_cnt;
    // One-cycle stage aligning every response with the memory read latency.
    logic               r_infl_vld;
    logic               r_infl_err;

    logic [31:0]        w_off;
    logic               w_in_range;
    logic               w_gnt;
    logic               w_rvalid;
    logic               w_empty;
    logic               w_full;
    obi_resp_t          w_push_data;
    obi_resp_t          w_head;

    // Unsigned offset: addresses below the base wrap to a huge value and
    // therefore fall out of range without a separate lower-bound compare.
    assign w_off      = obi_addr_i - ADDR_BASE;
    assign w_in_range = (w_off < ADDR_SIZE);

    // Credit comes from the registered count only; a pop in this cycle does
    // not free a slot until the next one.
    assign w_gnt    = obi_req_i && !gnt_stall_i && (r_cnt < c_DEPTH);
    assign w_rvalid = !w_empty && !rvalid_stall_i;

    assign obi_gnt_o    = w_gnt;
    assign obi_rvalid_o = w_rvalid;
    assign obi_rdata_o  = w_rvalid ? w_head.rdata : 32'h0;
    assign obi_err_o    = w_rvalid ? w_head.err   : 1'b0;

    assign mem_req_o  = w_gnt && w_in_range;
    assign mem_addr_o = w_off[MEM_AW+1:2];

    // Error responses ride through the same stage as reads so that ordering
    // relative to neighbouring in-range reads is preserved.
    assign w_push_data.rdata = r_infl_err ? ERR_RDATA : mem_rdata_i;
    assign w_push_data.err   = r_infl_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_infl_vld <= 1'b0;
            r_infl_err <= 1'b0;
        end else begin
            r_infl_vld <= w_gnt;
            r_infl_err <= w_gnt && !w_in_range;
            case ({w_gnt, w_rvalid})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    cv32e40p_obi_resp_fifo #(
        .DEPTH (DEPTH)
    ) u_resp_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_infl_vld),
        .i_data  (w_push_data),
        .i_pop   (w_rvalid),
        .o_head  (w_head),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!obi_gnt_o || obi_req_i);
            assert (r_cnt <= c_DEPTH);
            // A response can only exist for a transaction already counted.
            assert (!obi_rvalid_o || (r_cnt != '0));
            assert (!mem_req_o || (obi_gnt_o && w_in_range));
            assert (!(r_infl_vld && w_full && !w_rvalid));
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_cv32e40p_obi_instr_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_cv32e40p_obi_instr_responder
// Description : Self-checking bench for the instruction OBI responder.
//               A reference model keeps the expected responses as a queue of
//               {data, err, earliest cycle}; grant depends only on the model's
//               outstanding-transaction count.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cv32e40p_obi_instr_responder;

    localparam int          DEPTH     = 2;
    localparam logic [31:0] ADDR_BASE = 32'h0000_0000;
    localparam logic [31:0] ADDR_SIZE = 32'h0001_0000;
    localparam int          MEM_AW    = 14;
    localparam int          WORDS     = 1 << MEM_AW;

    logic              clk = 1'b0;
    logic              rst;
    logic              req;
    logic              gnt;
    logic [31:0]       addr;
    logic              rvalid;
    logic [31:0]       rdata;
    logic              err;
    logic              gstall;
    logic              rstall;
    logic              mem_req;
    logic [MEM_AW-1:0] mem_addr;
    logic [31:0]       mem_rdata;

    logic [31:0]       rom [WORDS];

    typedef struct {
        logic [31:0] d;
        logic        e;
        int          due;
    } exp_t;

    exp_t q[$];
    int   outstanding;
    int   cyc;
    int   tests;
    int   fails;

    always #5 clk = ~clk;

    cv32e40p_obi_instr_responder #(
        .DEPTH     (DEPTH),
        .ADDR_BASE (ADDR_BASE),
        .ADDR_SIZE (ADDR_SIZE),
        .MEM_AW    (MEM_AW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .obi_req_i      (req),
        .obi_gnt_o      (gnt),
        .obi_addr_i     (addr),
        .obi_rvalid_o   (rvalid),
        .obi_rdata_o    (rdata),
        .obi_err_o      (err),
        .gnt_stall_i    (gstall),
        .rvalid_stall_i (rstall),
        .mem_req_o      (mem_req),
        .mem_addr_o     (mem_addr),
        .mem_rdata_i    (mem_rdata)
    );

    // Synchronous ROM; garbage when not strobed so stray captures show up.
    always @(posedge clk) begin
        if (mem_req) mem_rdata <= rom[mem_addr];
        else         mem_rdata <= $urandom();
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One checked clock cycle: compare at negedge, advance model at posedge.
    task automatic tick(output bit granted);
        logic [31:0] off;
        logic        inr;
        logic        eg;
        logic        em;
        logic        ev;
        logic [31:0] ed;
        logic        ee;
        exp_t        ent;
        @(negedge clk);
        off = addr - ADDR_BASE;
        inr = (off < ADDR_SIZE);
        eg  = req && !gstall && (outstanding < DEPTH);
        em  = eg && inr;
        ev  = (q.size() > 0) && (q[0].due <= cyc) && !rstall;
        ed  = ev ? q[0].d : 32'h0;
        ee  = ev ? q[0].e : 1'b0;
        chk("gnt",     32'(gnt),     32'(eg));
        chk("mem_req", 32'(mem_req), 32'(em));
        if (em) chk("mem_addr", 32'(mem_addr), off >> 2);
        chk("rvalid",  32'(rvalid),  32'(ev));
        chk("rdata",   rdata,        ed);
        chk("err",     32'(err),     32'(ee));
        granted = eg;
        @(posedge clk);
        if (rst) begin
            q.delete();
            outstanding = 0;
        end else begin
            if (ev) begin
                void'(q.pop_front());
                outstanding--;
            end
            if (eg) begin
                ent.d   = inr ? rom[int'(off >> 2)] : 32'h0;
                ent.e   = !inr;
                ent.due = cyc + 2;
                q.push_back(ent);
                outstanding++;
            end
        end
        cyc++;
        #1;
    endtask

    task automatic idle(input int n);
        bit g;
        for (int k = 0; k < n; k++) tick(g);
    endtask

    // Hold a request until the model predicts a grant (bounded).
    task automatic issue(input logic [31:0] a);
        bit g;
        g    = 1'b0;
        req  = 1'b1;
        addr = a;
        for (int k = 0; k < 12 && !g; k++) tick(g);
        if (!g) chk("issue_timeout", 32'(g), 32'h1);
        req = 1'b0;
    endtask

    initial begin
        bit g;
        int r;
        tests = 0;
        fails = 0;
        cyc   = 0;
        outstanding = 0;
        for (int i = 0; i < WORDS; i++) rom[i] = $urandom();
        rom[0] = 32'hDEAD_BEEF;

        rst = 1'b1; req = 1'b0; addr = 32'h0; gstall = 1'b0; rstall = 1'b0;
        @(posedge clk);
        #1;
        // Reset state, with reset still asserted.
        idle(2);
        rst = 1'b0;
        idle(1);

        // Single read of word 0: data two cycles after grant.
        issue(ADDR_BASE);
        idle(3);

        // Streaming requests limited by DEPTH credits.
        for (int i = 0; i < 4; i++) issue(ADDR_BASE + 32'(i * 4));
        idle(4);

        // Response back-pressure with request held.
        rstall = 1'b1;
        req    = 1'b1;
        addr   = ADDR_BASE + 32'h10;
        idle(5);
        rstall = 1'b0;
        idle(4);
        req = 1'b0;
        idle(3);

        // Out-of-range request between two in-range reads.
        issue(ADDR_BASE + 32'h20);
        issue(ADDR_BASE + ADDR_SIZE);
        issue(ADDR_BASE + 32'h24);
        idle(4);

        // Unaligned low bits are ignored.
        issue(32'h0000_0003);
        idle(3);

        // Reset right after two grants drops everything in flight.
        issue(ADDR_BASE + 32'h40);
        issue(ADDR_BASE + 32'h44);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        idle(3);
        issue(ADDR_BASE + 32'h48);
        idle(3);

        // Randomised traffic with stalls, out-of-range hits and resets.
        for (int n = 0; n < 600; n++) begin
            req    = ($urandom_range(0, 3) != 0);
            gstall = ($urandom_range(0, 4) == 0);
            rstall = ($urandom_range(0, 3) == 0);
            rst    = ($urandom_range(0, 63) == 0);
            r      = $urandom_range(0, 9);
            if (r < 8)       addr = ADDR_BASE + $urandom_range(0, int'(ADDR_SIZE) - 1);
            else if (r == 8) addr = ADDR_BASE + ADDR_SIZE + $urandom_range(0, 255);
            else             addr = ADDR_BASE - 32'h4;
            tick(g);
        end

        req = 1'b0; gstall = 1'b0; rstall = 1'b0; rst = 1'b0;
        idle(5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
